// File: rtl/sdh_pkg.sv
// Shared SDH framing constants, FSM state type and the byte-parallel
// 1+x^6+x^7 keystream helper used by the TX scrambler and RX descrambler.
package sdh_pkg;

  localparam int STM_N       = 1;
  localparam int ROW_BYTES   = 270 * STM_N;
  localparam int FRAME_BYTES = 2430 * STM_N;
  localparam int UNSCR_BYTES = 9 * STM_N;
  localparam int CNT_W       = $clog2(FRAME_BYTES);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ZERO   = cnt_t'(0);
  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam cnt_t B1_POS     = cnt_t'(ROW_BYTES);
  localparam cnt_t FRAME_LAST = cnt_t'(FRAME_BYTES - 1);
  localparam cnt_t SCR_FIRST  = cnt_t'(UNSCR_BYTES);
  localparam cnt_t SEED_POS   = cnt_t'(UNSCR_BYTES - 1);

  localparam logic [7:0] SCR_SEED  = 8'hFE;
  // The 7 state bits are the first 7 keystream bits, so the seed byte's top 7 bits.
  localparam logic [6:0] SCR_STATE = SCR_SEED[7:1];

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    SYNC = 1'b1
  } frm_state_e;

  // Unrolls 15 sequence bits from state (state[6] is the next bit on the line):
  // result[14:7] is this byte's keystream, result[6:0] the state for the next byte.
  function automatic logic [14:0] lfsr_expand(input logic [6:0] st);
    logic [0:14] b;
    b[0:6] = st;
    for (int k = 7; k < 15; k++) begin
      b[k] = b[k-6] ^ b[k-7];
    end
    return b;
  endfunction

endpackage

// File: rtl/tx_scram_lfsr.sv
// Byte-parallel frame-synchronous scrambler keystream generator (1+x^6+x^7),
// with seed load and per-byte advance; shared with the RX descrambler.
module tx_scram_lfsr
  import sdh_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] ks
);

  logic [6:0]  state_r;
  logic [14:0] bits_s;

  assign bits_s = lfsr_expand(state_r);
  assign ks     = bits_s[14:7];

  // Keystream state: seed load takes priority over advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SCR_STATE;
    end else if (load) begin
      state_r <= SCR_STATE;
    end else if (adv) begin
      state_r <= bits_s[6:0];
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/tx_scram.sv
// STM-N transmit scrambler: B1 (BIP-8) generation/insertion, frame-synchronous
// scrambling of all but the first SOH row, and forced all-ones (AIS) output.
module tx_scram
  import sdh_pkg::*;
(
  input  logic       sdh_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_int_data,
  input  logic       tx_int_data_vld,
  input  logic       tx_frame_start,
  input  logic       tx_scramb_en,
  input  logic       tx_ais_en,
  input  logic [7:0] tx_b1_err_mask,
  output logic [7:0] tx_scr_data,
  output logic       tx_scr_data_vld,
  output logic [7:0] tx_b1,
  output logic       tx_sync
);

  frm_state_e state_r, state_nx;
  cnt_t       cnt_r, cnt_s, cnt_nx;
  logic       start_s, active_s, ais_r, vld_r, ks_load_s, ks_adv_s;
  logic [7:0] ks_s, byte_s, scr_s, out_s, acc_r, b1_hold_r, data_r;

  assign start_s = tx_int_data_vld & tx_frame_start;

  tx_scram_lfsr u_lfsr (
    .clk   (sdh_clk),
    .rst_n (rst_n),
    .load  (ks_load_s),
    .adv   (ks_adv_s),
    .ks    (ks_s)
  );

  // Framer state register.
  always_ff @(posedge sdh_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_nx;
    end
  end

  // Framer next state: SYNC is only left through reset.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      HUNT:    state_nx = start_s ? SYNC : HUNT;
      SYNC:    state_nx = SYNC;
      default: state_nx = HUNT;
    endcase
  end

  // Per-byte datapath; a frame start byte is already treated as count 0, even from HUNT.
  always_comb begin
    active_s  = (state_r == SYNC) || start_s;
    cnt_s     = start_s ? CNT_ZERO : cnt_r;
    cnt_nx    = (cnt_s == FRAME_LAST) ? CNT_ZERO : cnt_s + CNT_ONE;
    byte_s    = (active_s && (cnt_s == B1_POS)) ? (b1_hold_r ^ tx_b1_err_mask) : tx_int_data;
    scr_s     = (active_s && (cnt_s >= SCR_FIRST) && tx_scramb_en) ? (byte_s ^ ks_s) : byte_s;
    out_s     = ais_r ? 8'hFF : scr_s;
    ks_load_s = !tx_scramb_en || (active_s && tx_int_data_vld && (cnt_s == SEED_POS));
    ks_adv_s  = active_s && tx_int_data_vld && tx_scramb_en && (cnt_s >= SCR_FIRST);
  end

  // Byte counter and BIP-8 over the transmitted (post-scramble, post-AIS) bytes.
  always_ff @(posedge sdh_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= 8'h00;
      b1_hold_r <= 8'h00;
    end else if (!active_s) begin
      acc_r     <= 8'h00;
    end else if (tx_int_data_vld) begin
      cnt_r <= cnt_nx;
      if (cnt_s == CNT_ZERO) begin
        b1_hold_r <= acc_r;
        acc_r     <= out_s;
      end else begin
        acc_r     <= acc_r ^ out_s;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  // Line output registers; data holds across invalid cycles.
  always_ff @(posedge sdh_clk or negedge rst_n) begin
    if (!rst_n) begin
      ais_r  <= 1'b0;
      vld_r  <= 1'b0;
      data_r <= 8'h00;
    end else begin
      ais_r <= tx_ais_en;
      vld_r <= tx_int_data_vld;
      if (tx_int_data_vld) begin
        data_r <= out_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign tx_scr_data     = data_r;
  assign tx_scr_data_vld = vld_r;
  assign tx_b1           = b1_hold_r;
  assign tx_sync         = (state_r == SYNC);

endmodule

// File: doc/tx_scram.md
Name: tx_scram

Overview:
- Transmit-side STM-N frame-synchronous scrambler with B1 (BIP-8) generation and insertion, plus forced all-ones (AIS) output.
- Sits after the TX overhead inserter and before the line serializer.
- Byte-wide; its output is the exact inverse image of the RX descrambler input path.

Parameters:
- STM_N, 1, STM level. ROW_BYTES=270*STM_N, FRAME_BYTES=2430*STM_N, UNSCR_BYTES=9*STM_N.

Ports:
- sdh_clk  in  1  system byte clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_int_data  in  8  unscrambled frame byte stream.
- tx_int_data_vld  in  1  byte valid.
- tx_frame_start  in  1  with vld, marks frame byte 0 (first A1).
- tx_scramb_en  in  1  1 = scramble, 0 = bypass.
- tx_ais_en  in  1  force output 0xFF.
- tx_b1_err_mask  in  8  XORed into the inserted B1 (error injection); 0 in normal use.
- tx_scr_data  out  8  line byte.
- tx_scr_data_vld  out  1  line byte valid.
- tx_b1  out  8  last completed-frame BIP-8 (monitor).
- tx_sync  out  1  framer state (1 = SYNC).

Behaviour:
- Reset: tx_scr_data=0, tx_scr_data_vld=0, tx_b1=0, tx_sync=0, byte counter=0, BIP accumulator=0, keystream=seed.
- Latency: 1 cycle. tx_scr_data_vld is tx_int_data_vld delayed by one cycle.
- On a vld-low cycle, the counter, keystream and accumulator hold. tx_scr_data holds its last value.

FSM:
- HUNT (reset state): bytes pass through unmodified. No scrambling, no B1 insertion, accumulator cleared.
- HUNT -> SYNC on vld & tx_frame_start. That byte is counter 0.
- SYNC: the counter increments on each vld byte and wraps FRAME_BYTES-1 -> 0 (flywheel).
- A tx_frame_start at any count realigns the counter to 0 in that cycle. A partial frame is still latched as BIP.
- SYNC never returns to HUNT except by reset.

Byte processing in SYNC, for each vld byte at count c:
- c == ROW_BYTES (B1 position, row 2 col 1): input byte is replaced by b1_hold ^ tx_b1_err_mask before scrambling.
- c < UNSCR_BYTES: output = byte (first SOH row never scrambled).
- Otherwise, if tx_scramb_en: output = byte ^ keystream.
- Otherwise: output = byte.

Keystream:
- Generator polynomial 1+x^6+x^7, MSB transmitted first.
- Re-seeded at c == UNSCR_BYTES-1 so the first scrambled byte uses 0xFE.
- Sequence continues FE, 04, 18, 51, E4, 59, ...
- Advances one byte per vld byte at c >= UNSCR_BYTES.
- While tx_scramb_en=0, the keystream is held at seed.

AIS:
- tx_ais_en is registered once (ais_r); ais_r overrides all else, output = 0xFF.
- Counter, keystream and BIP continue running.

BIP:
- The accumulator XORs every output byte, including AIS and unscrambled bytes.
- On a vld byte at c == 0: b1_hold <= accumulator, accumulator <= output byte 0.
- tx_b1 mirrors b1_hold. b1_hold = 0 until the first complete frame.

Simultaneous events:
- tx_frame_start at c == ROW_BYTES: realign wins, and the byte is treated as byte 0.
- tx_frame_start without vld is ignored.
- Async reset mid-frame returns to HUNT immediately.

Decomposition:
- Package sdh_pkg holds:
  - STM_N-derived constants ROW_BYTES, FRAME_BYTES, UNSCR_BYTES.
  - SCR_SEED=8'hFE.
  - FSM state enum {HUNT, SYNC}.
- Sub-module tx_scram_lfsr: holds the 7-bit state, byte-parallel next-state/keystream, seed-load and advance inputs. Reusable by the RX descrambler.

Test Plan:
- All-zero payload, tx_scramb_en=1, frame_start at byte 0 -> out bytes 0..8 = 0x00; bytes 9..12 = FE,04,18,51; vld delayed 1 cycle.
- tx_scramb_en=0, frame 1 all zero except byte 0 = 0xF6 -> frame 2 byte 270 out = 0xF6, tx_b1=0xF6. With tx_b1_err_mask=0x01 -> 0xF7.
- Scrambled random frames -> each B1 at byte 270 equals the reference-model XOR of the previous frame's output bytes. Descrambling through the RX model returns the input.
- tx_ais_en=1 mid-frame -> output 0xFF from the second vld byte onward. Next-frame B1 reflects those 0xFF bytes. Deasserting resumes the in-phase keystream.
- vld gaps of 1-5 cycles and early frame_start at count 1000 -> output stream identical to the gap-free stream with the counter realigned. No keystream slip.
- Reset asserted mid-frame -> all outputs 0 next edge; HUNT passthrough until the next frame_start.
